// File: rtl/ase_umsg_sched.sv
// ase_umsg_sched: per-slot UMsg hint/data delay scheduler with round-robin Rx arbitration.
// Optional hint path: define ASE_UMSG_HINT_EN (default build emits data UMsgs only).
module ase_umsg_sched #(
  parameter  int NUM_UMSG   = 8,
  parameter  int HINT_DELAY = 16,
  parameter  int DATA_DELAY = 32,
  localparam int IDW        = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_UMSG-1:0]   hint_en,
  input  logic                  cmd_valid,
  input  logic [IDW-1:0]        cmd_id,
  input  logic [511:0]          cmd_data,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  output logic [27:0]           rsp_hdr,
  output logic [511:0]          rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [NUM_UMSG*3-1:0] dbg_state
);

  typedef enum logic [2:0] {
    UMSG_IDLE      = 3'd0,
    UMSG_HINT_WAIT = 3'd1,
    UMSG_SEND_HINT = 3'd2,
    UMSG_DATA_WAIT = 3'd3,
    UMSG_SEND_DATA = 3'd4
  } umsg_state_e;

  // Header layout: resp_type [15:12], umsg_type [11] (1=hint), umsg_id [5:0], rest zero.
  localparam logic [3:0] RESP_UMSG = 4'h6;
  localparam logic [5:0] DATA_LOAD = 6'(DATA_DELAY - 1);
`ifdef ASE_UMSG_HINT_EN
  localparam logic [5:0] HINT_LOAD = 6'(HINT_DELAY - 1);
`endif

  umsg_state_e    r_state [NUM_UMSG];
  logic [5:0]     r_timer [NUM_UMSG];
  logic [511:0]   r_data  [NUM_UMSG];
  logic [IDW-1:0] r_rr_ptr;
  logic           r_rsp_valid;
  logic [27:0]    r_rsp_hdr;
  logic [511:0]   r_rsp_data;
  logic           r_busy;

  umsg_state_e    w_state_nxt [NUM_UMSG];
  logic [5:0]     w_timer_nxt [NUM_UMSG];
  logic [NUM_UMSG-1:0] w_elig;
  logic           w_id_legal;
  logic           w_accept;
  logic           w_load;
  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_id;
  logic           w_grant_hint;
  logic [27:0]    w_hdr_nxt;
  logic [511:0]   w_data_nxt;
  logic           w_busy_nxt;

`ifndef ASE_UMSG_HINT_EN
  logic w_unused_hint;
  assign w_unused_hint = ^hint_en;
`endif

  // Handshakes: a command transfers on an edge where cmd_valid && cmd_ready; a UMsg transfers
  // on an edge where rsp_valid && rsp_ready, and rsp_* stay frozen while rsp_valid && !rsp_ready.
  assign w_id_legal = 32'(cmd_id) < 32'(NUM_UMSG);
  assign cmd_ready  = w_id_legal && (r_state[cmd_id] == UMSG_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_load     = !r_rsp_valid || rsp_ready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_hdr   = r_rsp_hdr;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

  always_comb begin
    dbg_state = '0;
    for (int s = 0; s < NUM_UMSG; s++) dbg_state[s*3 +: 3] = r_state[s];
  end

  // Round-robin pick starting one past the last granted slot.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    idx         = 0;
    cand        = '0;
    w_elig      = '0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int s = 0; s < NUM_UMSG; s++) begin
`ifdef ASE_UMSG_HINT_EN
      w_elig[s] = (r_state[s] == UMSG_SEND_DATA) || (r_state[s] == UMSG_SEND_HINT);
`else
      w_elig[s] = (r_state[s] == UMSG_SEND_DATA);
`endif
    end
    for (int i = 1; i <= NUM_UMSG; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_UMSG) idx = idx - NUM_UMSG;
      cand = IDW'(idx);
      if (!w_grant_vld && w_elig[cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = cand;
      end
    end
  end

  always_comb begin
    w_grant_hint = 1'b0;
`ifdef ASE_UMSG_HINT_EN
    w_grant_hint = (r_state[w_grant_id] == UMSG_SEND_HINT);
`endif
    w_hdr_nxt        = '0;
    w_hdr_nxt[15:12] = RESP_UMSG;
    w_hdr_nxt[11]    = w_grant_hint;
    w_hdr_nxt[5:0]   = 6'(w_grant_id);
    w_data_nxt       = w_grant_hint ? '0 : r_data[w_grant_id];
  end

  always_comb begin
    logic won;
    won = 1'b0;
    for (int s = 0; s < NUM_UMSG; s++) begin
      w_state_nxt[s] = r_state[s];
      w_timer_nxt[s] = r_timer[s];
      won = w_load && w_grant_vld && (w_grant_id == IDW'(s));
      case (r_state[s])
        UMSG_IDLE: begin
          if (w_accept && (cmd_id == IDW'(s))) begin
`ifdef ASE_UMSG_HINT_EN
            if (hint_en[s]) begin
              w_state_nxt[s] = UMSG_HINT_WAIT;
              w_timer_nxt[s] = HINT_LOAD;
            end else
`endif
            begin
              w_state_nxt[s] = UMSG_DATA_WAIT;
              w_timer_nxt[s] = DATA_LOAD;
            end
          end
        end
`ifdef ASE_UMSG_HINT_EN
        UMSG_HINT_WAIT: begin
          if (r_timer[s] == 6'd0) w_state_nxt[s] = UMSG_SEND_HINT;
          else                    w_timer_nxt[s] = r_timer[s] - 6'd1;
        end
        UMSG_SEND_HINT: begin
          if (won) begin
            w_state_nxt[s] = UMSG_DATA_WAIT;
            w_timer_nxt[s] = DATA_LOAD;
          end
        end
`endif
        UMSG_DATA_WAIT: begin
          if (r_timer[s] == 6'd0) w_state_nxt[s] = UMSG_SEND_DATA;
          else                    w_timer_nxt[s] = r_timer[s] - 6'd1;
        end
        UMSG_SEND_DATA: begin
          if (won) w_state_nxt[s] = UMSG_IDLE;
        end
        default: begin
          w_state_nxt[s] = UMSG_IDLE;
          w_timer_nxt[s] = '0;
        end
      endcase
    end
  end

  // busy reflects the state being registered this edge, so it has no extra cycle of lag.
  always_comb begin
    w_busy_nxt = w_load ? w_grant_vld : r_rsp_valid;
    for (int s = 0; s < NUM_UMSG; s++) begin
      if (w_state_nxt[s] != UMSG_IDLE) w_busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_UMSG; s++) begin
        r_state[s] <= UMSG_IDLE;
        r_timer[s] <= '0;
      end
      r_rsp_valid <= 1'b0;
      r_rsp_hdr   <= '0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_UMSG; s++) begin
        r_state[s] <= w_state_nxt[s];
        r_timer[s] <= w_timer_nxt[s];
      end
      if (w_load) begin
        r_rsp_valid <= w_grant_vld;
        if (w_grant_vld) begin
          r_rsp_hdr  <= w_hdr_nxt;
          r_rsp_data <= w_data_nxt;
          r_rr_ptr   <= w_grant_id;
        end else begin
          r_rsp_hdr  <= '0;
          r_rsp_data <= '0;
        end
      end
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_data[cmd_id] <= cmd_data;
  end

endmodule

// File: tb/tb_ase_umsg_sched.sv
// Bench for ase_umsg_sched: directed scenarios plus random traffic against a timestamp model.
// Honours ASE_UMSG_HINT_EN the same way the design does.
module tb_ase_umsg_sched;
  localparam int N   = 8;
  localparam int H   = 16;
  localparam int D   = 32;
  localparam int IDW = 3;
`ifdef ASE_UMSG_HINT_EN
  localparam bit HINT_ON = 1'b1;
`else
  localparam bit HINT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   hint_en;
  logic           cmd_valid;
  logic [IDW-1:0] cmd_id;
  logic [511:0]   cmd_data;
  logic           cmd_ready;
  logic           rsp_valid;
  logic [27:0]    rsp_hdr;
  logic [511:0]   rsp_data;
  logic           rsp_ready;
  logic           busy;
  logic [N*3-1:0] dbg_state;

  ase_umsg_sched #(.NUM_UMSG(N), .HINT_DELAY(H), .DATA_DELAY(D)) dut (
    .clk(clk), .rst(rst), .hint_en(hint_en), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #10 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [539:0] exp_q[$];

  // model: each busy slot becomes sendable once the edge count passes m_elig
  bit           m_busy [N];
  bit           m_hint [N];
  int           m_elig [N];
  logic [511:0] m_data [N];
  bit           m_valid;
  logic [27:0]  m_hdr;
  logic [511:0] m_rdata;
  int           m_last;
  int           m_edge;

  task automatic check(input string tag, input logic [539:0] got, input logic [539:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk_hdr(input bit hint, input int id);
    logic [27:0] h;
    h = '0;
    h[15:12] = 4'h6;
    h[11]    = hint;
    h[5:0]   = id[5:0];
    return h;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_busy[s] = 0; m_hint[s] = 0; m_elig[s] = 0; m_data[s] = '0;
    end
    m_valid = 0; m_hdr = '0; m_rdata = '0; m_last = 0;
    exp_q.delete();
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_valid;
    for (int s = 0; s < N; s++) if (m_busy[s]) b = 1;
    return b;
  endfunction

  // driver: one full cycle, starting and ending at a falling edge
  task automatic step(input bit v, input logic [IDW-1:0] id, input logic [511:0] d,
                      input logic [N-1:0] he, input bit rr, input bit r);
    bit acc;
    int pick;
    int idx;
    cmd_valid = v; cmd_id = id; cmd_data = d; hint_en = he; rsp_ready = rr; rst = r;
    #1;
    if (!r) begin
      check("cmd_ready", cmd_ready, !m_busy[id]);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("deliver_extra", 1'b1, 1'b0);
        else check("deliver", {rsp_hdr, rsp_data}, exp_q.pop_front());
      end
    end
    @(posedge clk);
    m_edge++;
    if (r) begin
      model_reset();
    end else begin
      acc = v && !m_busy[id];
      if (!m_valid || rr) begin
        pick = -1;
        for (int j = 1; j <= N; j++) begin
          idx = (m_last + j) % N;
          if (pick < 0 && m_busy[idx] && m_elig[idx] < m_edge) pick = idx;
        end
        if (pick < 0) begin
          m_valid = 0; m_hdr = '0; m_rdata = '0;
        end else begin
          m_valid = 1;
          m_hdr   = mk_hdr(m_hint[pick], pick);
          m_rdata = m_hint[pick] ? '0 : m_data[pick];
          m_last  = pick;
          if (m_hint[pick]) begin
            m_hint[pick] = 0;
            m_elig[pick] = m_edge + D;
          end else begin
            m_busy[pick] = 0;
          end
          exp_q.push_back({m_hdr, m_rdata});
        end
      end
      if (acc) begin
        m_busy[id] = 1;
        m_data[id] = d;
        m_hint[id] = HINT_ON && he[id];
        m_elig[id] = m_edge + (m_hint[id] ? H : D);
      end
    end
    #1;
    check("rsp_valid", rsp_valid, m_valid);
    check("rsp_hdr", rsp_hdr, m_hdr);
    check("rsp_data", rsp_data, m_rdata);
    check("busy", busy, model_busy());
    @(negedge clk);
  endtask

  task automatic idle(input bit rr);
    step(1'b0, '0, '0, '0, rr, 1'b0);
  endtask

  // idles with rsp_ready=1 until rsp_valid rises; returns edges elapsed since start_edge
  task automatic wait_valid(input int start_edge, input int budget, output int lat);
    int cnt;
    cnt = 0;
    do begin
      idle(1'b1);
      cnt++;
    end while (!rsp_valid && cnt < budget);
    if (!rsp_valid) check("wait_timeout", 1'b0, 1'b1);
    lat = m_edge - start_edge;
  endtask

  initial begin
    int t0;
    int lat;
    int seen;
    logic [539:0] snap;
    logic [511:0] pat_a;
    logic [511:0] pat_b;
    pat_a = {64{8'hA5}};
    pat_b = {64{8'h3C}};
    m_edge = 0;
    model_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_data = '0; hint_en = '0; rsp_ready = 1'b1;
    @(negedge clk);
    repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b1);

    // every legal id is ready in the first cycle out of reset
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      cmd_id = IDW'(i);
      #1;
      check("ready_after_rst", cmd_ready, 1'b1);
    end

    // single data UMsg, slot 0, no hint
    step(1'b1, 3'd0, pat_b, '0, 1'b1, 1'b0);
    t0 = m_edge;
    wait_valid(t0, 100, lat);
    check("data_latency", lat, D + 1);
    check("data_type", rsp_hdr[11], 1'b0);
    check("data_id", rsp_hdr[5:0], 6'd0);
    check("data_payload", rsp_data, pat_b);
    cmd_id = 3'd0; cmd_valid = 1'b0;
    #1;
    check("slot0_ready_after", cmd_ready, 1'b1);
    idle(1'b1);

`ifdef ASE_UMSG_HINT_EN
    // hint then data, slot 3
    step(1'b1, 3'd3, pat_a, 8'b0000_1000, 1'b1, 1'b0);
    t0 = m_edge;
    wait_valid(t0, 100, lat);
    check("hint_latency", lat, H + 1);
    check("hint_type", rsp_hdr[11], 1'b1);
    check("hint_id", rsp_hdr[5:0], 6'd3);
    check("hint_data_zero", rsp_data, 512'd0);
    t0 = m_edge;
    wait_valid(t0, 100, lat);
    check("hint_to_data", lat, D + 1);
    check("hint_data_type", rsp_hdr[11], 1'b0);
    check("hint_data_payload", rsp_data, pat_a);
    idle(1'b1);
`endif

    // slots 1, 2, 5 accepted back to back arrive in that order on consecutive cycles
    step(1'b1, 3'd1, rand_line(), '0, 1'b1, 1'b0);
    t0 = m_edge;
    step(1'b1, 3'd2, rand_line(), '0, 1'b1, 1'b0);
    step(1'b1, 3'd5, rand_line(), '0, 1'b1, 1'b0);
    wait_valid(t0, 100, lat);
    check("rr_first_lat", lat, D + 1);
    check("rr_seq0", rsp_hdr[5:0], 6'd1);
    idle(1'b1);
    check("rr_seq1", {rsp_valid, rsp_hdr[5:0]}, {1'b1, 6'd2});
    idle(1'b1);
    check("rr_seq2", {rsp_valid, rsp_hdr[5:0]}, {1'b1, 6'd5});
    idle(1'b1);

    // stall: two slots pending while rsp_ready=0
    step(1'b1, 3'd6, rand_line(), '0, 1'b0, 1'b0);
    step(1'b1, 3'd7, rand_line(), '0, 1'b0, 1'b0);
    seen = 0;
    while (!rsp_valid && seen < 60) begin
      idle(1'b0);
      seen++;
    end
    check("stall_valid", rsp_valid, 1'b1);
    check("stall_first_id", rsp_hdr[5:0], 6'd6);
    snap = {rsp_hdr, rsp_data};
    for (int k = 0; k < 10; k++) begin
      idle(1'b0);
      check("stall_hold", {rsp_hdr, rsp_data}, snap);
    end
    idle(1'b1);
    check("stall_second", {rsp_valid, rsp_hdr[5:0]}, {1'b1, 6'd7});
    idle(1'b1);
    check("stall_drained", rsp_valid, 1'b0);

    // repeat command to a busy slot 4 is refused until its data UMsg loads
    step(1'b1, 3'd4, pat_a, '0, 1'b1, 1'b0);
    t0 = m_edge;
    cmd_valid = 1'b1; cmd_id = 3'd4; cmd_data = pat_b;
    #1;
    check("slot4_busy", cmd_ready, 1'b0);
    step(1'b1, 3'd4, pat_b, '0, 1'b1, 1'b0);
    wait_valid(t0, 100, lat);
    check("slot4_first", rsp_data, pat_a);
    cmd_valid = 1'b1; cmd_id = 3'd4;
    #1;
    check("slot4_ready_again", cmd_ready, 1'b1);
    step(1'b1, 3'd4, pat_b, '0, 1'b1, 1'b0);
    t0 = m_edge;
    wait_valid(t0, 100, lat);
    check("slot4_second_lat", lat, D + 1);
    check("slot4_second", rsp_data, pat_b);
    idle(1'b1);

    // reset with work in flight drops everything
    for (int s = 0; s < 4; s++) step(1'b1, IDW'(s), rand_line(), '1, 1'b1, 1'b0);
    repeat (5) idle(1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    check("rst_mid_valid", rsp_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      idle(1'b1);
      if (rsp_valid) seen++;
    end
    check("rst_mid_no_emit", seen, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 2) == 0, IDW'($urandom_range(0, N - 1)), rand_line(),
           N'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 599) == 0);
    end

    repeat (150) idle(1'b1);
    check("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ase_umsg_sched.md
ASE_UMSG_SCHED -- requirements
Module: ase_umsg_sched

Interface
REQ-001 SHALL have parameter NUM_UMSG, default 8, the number of UMsg slots per AFU (ids 0..NUM_UMSG-1).
REQ-002 SHALL have parameter HINT_DELAY, default 16, the HintWait duration in cycles (legal range 1..63).
REQ-003 SHALL have parameter DATA_DELAY, default 32, the DataWait duration in cycles (legal range 1..63).
REQ-004 clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 hint_en  in  NUM_UMSG  per-slot hint enable, sampled at command acceptance.
REQ-007 cmd_valid  in  1  UMsg write command present.
REQ-008 cmd_id  in  $clog2(NUM_UMSG)  target slot of the command.
REQ-009 cmd_data  in  512  UMsg line data.
REQ-010 cmd_ready  out  1  high when slot cmd_id is Idle; combinational from registered slot state and cmd_id.
REQ-011 rsp_valid  out  1  registered; a UMsg is presented on the Rx channel.
REQ-012 rsp_hdr  out  28  UMsgHdr_t fields: resp_type=ASE_UMSG (4'h6), umsg_type (1=hint, 0=data), umsg_id=slot; all other bits 0.
REQ-013 rsp_data  out  512  slot data for a data UMsg; all zeros for a hint.
REQ-014 rsp_ready  in  1  the Rx channel accepts rsp_* this cycle.
REQ-015 busy  out  1  registered; high while any slot is not Idle or rsp_valid is high.

Function
REQ-016 Each slot SHALL run the FSM UMsgIdle -> UMsgHintWait -> UMsgSendHint -> UMsgDataWait -> UMsgSendData -> UMsgIdle.
REQ-017 A command SHALL be accepted only when cmd_valid && cmd_ready; on acceptance the slot latches cmd_data and the slot's hint_en value.
REQ-018 On acceptance with the latched hint_en=1, the slot SHALL enter HintWait with its timer loaded to HINT_DELAY-1; with hint_en=0 it SHALL enter DataWait with its timer loaded to DATA_DELAY-1.
REQ-019 In HintWait/DataWait, the timer SHALL decrement once per cycle; the wait state lasts exactly HINT_DELAY or DATA_DELAY cycles, and on timer==0 the slot moves to SendHint or SendData respectively.
REQ-020 The output register SHALL load when !rsp_valid || rsp_ready.
REQ-021 When the output register loads, a round-robin arbiter SHALL pick one slot in SendHint or SendData, searching from (last granted slot + 1) mod NUM_UMSG.
REQ-022 The picked slot SHALL transition SendHint -> DataWait (timer loaded to DATA_DELAY-1) or SendData -> Idle in the same edge that loads rsp_*.
REQ-023 If the output register loads and no slot is eligible, rsp_valid SHALL go to 0.
REQ-024 Latency: a slot entering SendHint/SendData at edge N with an empty output register SHALL drive rsp_valid=1 after edge N+1.
REQ-025 Throughput: back-to-back UMsgs SHALL be presented at one per cycle while rsp_ready=1.
REQ-026 rsp_* SHALL be held stable while rsp_valid && !rsp_ready.
REQ-027 A slot returning to Idle at edge N SHALL raise cmd_ready from cycle N+1; a command held at that slot is not accepted before then.
REQ-028 cmd_valid with cmd_id >= NUM_UMSG SHALL be ignored, with cmd_ready=0.

Reset
REQ-029 While rst=1: all slots SHALL be Idle, timers 0, rsp_valid=0, rsp_hdr=0, rsp_data=0, round-robin pointer=0, busy=0.
REQ-030 Asserting rst mid-operation SHALL drop all pending UMsgs with no partial output.
REQ-031 cmd_ready SHALL be 1 for any legal cmd_id in the first cycle after rst deasserts.

Configuration
REQ-032 With ASE_UMSG_HINT_EN defined, the hint path SHALL behave per REQ-016..REQ-018.
REQ-033 With ASE_UMSG_HINT_EN undefined, hint_en SHALL be ignored, HintWait and SendHint logic SHALL be compiled out, and every accepted command SHALL enter DataWait directly; umsg_type is then always 0.

Verification
REQ-034 Scenario: ASE_UMSG_HINT_EN defined, hint_en[3]=1, cmd id 3, data 0xA5.., rsp_ready=1 -> hint (umsg_type=1, id 3, data 0) 17 cycles after acceptance, then a data UMsg (umsg_type=0, data 0xA5..) 33 cycles after the hint.
REQ-035 Scenario: hint_en=0, cmd id 0 -> a single data UMsg 33 cycles after acceptance, no hint; slot 0 cmd_ready high the cycle after.
REQ-036 Scenario: commands to slots 1, 2, 5 accepted on the same edge-aligned timing (one per cycle, hint off), rsp_ready=1 -> data UMsgs on three consecutive cycles in order 1, 2, 5.
REQ-037 Scenario: rsp_ready=0 for 10 cycles with two slots in SendData -> rsp_* held constant, the second slot waits, both delivered on consecutive cycles once rsp_ready=1.
REQ-038 Scenario: second command to slot 4 while slot 4 is in DataWait -> cmd_ready=0, not accepted; accepted the cycle after slot 4's data UMsg is loaded.
REQ-039 Scenario: rst asserted for 1 cycle with slots in HintWait -> rsp_valid=0, busy=0, no UMsg emitted afterward.
